// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter: FSM state encodings.
package shared_reg_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of (req & ~mask) starting at ptr.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [NREQ-1:0] cand;

  assign cand = req & ~mask;

  // Scan from farthest to nearest so the nearest hit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand[(int'(ptr) + k) % NREQ]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting NREQ requesters write access to one shared WIDTH-bit register.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter  int               NREQ    = 4,
  parameter  int               WIDTH   = 8,
  parameter  logic [WIDTH-1:0] RST_VAL = '0,
  localparam int               IW      = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic [IW-1:0]         owner,
  output logic                  busy
);

  arb_state_t             state, state_n;
  logic [IW-1:0]          ptr, ptr_n, owner_n, owner_nxt;
  logic [NREQ-1:0]        gnt_n, ack_n, pick_mask;
  logic [IW-1:0]          pick_ptr, pick_idx;
  logic                   pick_vld, we, keep;
  logic [NREQ-1:0][WIDTH-1:0] wd;
  logic [WIDTH-1:0]       q_n;

  assign wd        = wdata;
  assign busy      = (state == ST_OWNED);
  assign we        = busy && req[owner];
  assign keep      = req[owner] && lock[owner];
  assign owner_nxt = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);

  // While owned, the handoff search starts just past the owner and skips it.
  always_comb begin
    pick_mask = '0;
    pick_ptr  = ptr;
    if (busy) begin
      pick_mask[owner] = 1'b1;
      pick_ptr         = owner_nxt;
    end
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .mask  (pick_mask),
    .ptr   (pick_ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    owner_n = owner;
    ack_n   = '0;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          state_n         = ST_OWNED;
          owner_n         = pick_idx;
          gnt_n           = '0;
          gnt_n[pick_idx] = 1'b1;
        end
      end
      ST_OWNED: begin
        if (we) ack_n[owner] = 1'b1;
        if (!keep) begin
          ptr_n = owner_nxt;
          if (pick_vld) begin
            owner_n         = pick_idx;
            gnt_n           = '0;
            gnt_n[pick_idx] = 1'b1;
          end else begin
            state_n = ST_IDLE;
            gnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  // Storage D-input mux: load the owner's data or recirculate q.
  assign q_n = we ? wd[owner] : q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      gnt   <= '0;
      owner <= '0;
      ack   <= '0;
      q     <= RST_VAL;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gnt   <= gnt_n;
      owner <= owner_n;
      ack   <= ack_n;
      q     <= q_n;
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (NREQ=4, WIDTH=8, RST_VAL=0).
module tb_shared_reg_arbiter;

  logic        clk, rst_n;
  logic [3:0]  req, lock, gnt, ack;
  logic [31:0] wdata;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        busy;
  int          n_cmp, n_err;

  shared_reg_arbiter #(.NREQ(4), .WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .lock  (lock),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .q     (q),
    .owner (owner),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    wdata = '0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 4'b1111;
    lock  = '0;
    wdata = '0;

    // 1: reset state, then first grant after release
    step(); step();
    chk("t1 rst gnt",  gnt,  4'b0000);
    chk("t1 rst ack",  ack,  4'b0000);
    chk("t1 rst q",    q,    8'h00);
    chk("t1 rst busy", busy, 1'b0);
    rst_n = 1'b1;
    step();
    chk("t1 first gnt", gnt, 4'b0001);
    req = '0;
    step();
    chk("t1 no write q", q,   8'h00);
    chk("t1 no ack",     ack, 4'b0000);

    // 2: single requester latency
    do_reset();
    req = 4'b0100;
    wdata[23:16] = 8'hA5;
    step();
    chk("t2 gnt c1",  gnt,  4'b0100);
    chk("t2 busy c1", busy, 1'b1);
    chk("t2 ack c1",  ack,  4'b0000);
    step();
    chk("t2 q c2",    q,    8'hA5);
    chk("t2 ack c2",  ack,  4'b0100);
    chk("t2 gnt c2",  gnt,  4'b0000);
    chk("t2 busy c2", busy, 1'b0);
    req = '0;
    step();
    chk("t2 ack pulse", ack, 4'b0000);

    // 3: full contention, one write per cycle, rotating
    do_reset();
    req   = 4'b1111;
    wdata = 32'h13121110;
    step();
    chk("t3 gnt c1", gnt, 4'b0001);
    step();
    chk("t3 gnt c2", gnt, 4'b0010);
    chk("t3 q c2",   q,   8'h10);
    chk("t3 ack c2", ack, 4'b0001);
    req = 4'b1110;
    step();
    chk("t3 gnt c3", gnt, 4'b0100);
    chk("t3 q c3",   q,   8'h11);
    chk("t3 ack c3", ack, 4'b0010);
    req = 4'b1100;
    step();
    chk("t3 gnt c4",   gnt,   4'b1000);
    chk("t3 q c4",     q,     8'h12);
    chk("t3 owner c4", owner, 2'd3);
    req = 4'b1000;
    step();
    chk("t3 q c5",   q,   8'h13);
    chk("t3 ack c5", ack, 4'b1000);
    chk("t3 gnt c5", gnt, 4'b0000);
    req = '0;
    step();

    // 4: locked owner keeps grant across three writes, then hands off
    do_reset();
    req  = 4'b0010;
    lock = 4'b0010;
    wdata[15:8] = 8'h22;
    step();
    chk("t4 gnt", gnt, 4'b0010);
    req = 4'b0011;
    step();
    chk("t4 q 22",   q,   8'h22);
    chk("t4 ack 22", ack, 4'b0010);
    chk("t4 gnt 22", gnt, 4'b0010);
    wdata[15:8] = 8'h33;
    step();
    chk("t4 q 33",   q,   8'h33);
    chk("t4 ack 33", ack, 4'b0010);
    chk("t4 gnt 33", gnt, 4'b0010);
    wdata[15:8] = 8'h44;
    lock = '0;
    step();
    chk("t4 q 44",     q,     8'h44);
    chk("t4 ack 44",   ack,   4'b0010);
    chk("t4 handoff",  gnt,   4'b0001);
    chk("t4 owner",    owner, 2'd0);
    req = 4'b0001;
    wdata[7:0] = 8'h55;
    step();
    chk("t4 q 55",   q,   8'h55);
    chk("t4 ack 55", ack, 4'b0001);
    chk("t4 idle",   gnt, 4'b0000);
    req = '0;
    step();

    // 5: asynchronous reset mid-lock, then ptr back at 0
    do_reset();
    req  = 4'b0010;
    lock = 4'b0010;
    wdata[15:8] = 8'h66;
    step();
    step();
    chk("t5 q pre", q, 8'h66);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5 async gnt",   gnt,   4'b0000);
    chk("t5 async ack",   ack,   4'b0000);
    chk("t5 async q",     q,     8'h00);
    chk("t5 async busy",  busy,  1'b0);
    chk("t5 async owner", owner, 2'd0);
    req  = 4'b0011;
    lock = '0;
    step();
    rst_n = 1'b1;
    step();
    chk("t5 ptr reset gnt", gnt,   4'b0001);
    chk("t5 ptr reset own", owner, 2'd0);
    req = '0;
    step();
    step();

    // 6: locked owner drops req: no write, grant passes on
    do_reset();
    req  = 4'b1000;
    lock = 4'b1000;
    wdata[31:24] = 8'h5A;
    step();
    chk("t6 gnt", gnt, 4'b1000);
    step();
    chk("t6 q 5A", q, 8'h5A);
    req = 4'b0001;
    wdata[31:24] = 8'h77;
    step();
    chk("t6 q hold",  q,   8'h5A);
    chk("t6 no ack",  ack, 4'b0000);
    chk("t6 handoff", gnt, 4'b0001);
    req  = '0;
    lock = '0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
